// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned ARB_N     = 8;
    localparam int unsigned ARB_IDX_W = 3;

    // Arbiter FSM: IDLE arbitrates, BUSY holds the current owner.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick_8.sv
// Combinational round-robin pick: first set bit of req scanning ptr+1, ptr+2, ... mod 8.
// Ports:
//   req      in   8  request vector
//   ptr      in   3  last owner; the scan starts just after it
//   pick_oh  out  8  one-hot winner (zero when req is zero)
//   pick_idx out  3  index of the winner (zero when req is zero)
//   pick_any out  1  at least one request is set
module rr_pick_8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_N-1:0]     pick_oh,
    output logic [ARB_IDX_W-1:0] pick_idx,
    output logic                 pick_any
);

    logic [2*ARB_N-1:0]   req_dbl;
    logic [ARB_IDX_W:0]   shamt;
    logic [ARB_N-1:0]     req_rot;
    logic [ARB_IDX_W-1:0] off;

    // Rotate so that requester ptr+1 lands on bit 0, scan for the lowest
    // set bit, then add the rotation back to recover the absolute index.
    always_comb begin
        req_dbl  = {req, req};
        shamt    = {1'b0, ptr} + (ARB_IDX_W+1)'(1);
        req_rot  = ARB_N'(req_dbl >> shamt);
        off      = '0;
        pick_any = |req;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = ARB_IDX_W'(i);
            end
        end
        pick_idx = pick_any ? ptr + ARB_IDX_W'(1) + off : '0;
        pick_oh  = pick_any ? (ARB_N'(1) << pick_idx) : '0;
    end

endmodule : rr_pick_8

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among 8 requesters, with a hold limit.
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   en         in   1  arbitration enable (does not cut an active grant)
//   req        in   8  request vector
//   rel        in   8  release pulse, honoured only for the current owner
//   grant_oh   out  8  registered one-hot grant
//   grant_idx  out  3  registered index of grant_oh (0 when idle)
//   grant_vld  out  1  a grant is held
//   preempt    out  1  one-cycle pulse after a hold-limit eviction
//   none_req   out  1  req was all-zero at the previous edge
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_N-1:0]     rel,
    output logic [ARB_N-1:0]     grant_oh,
    output logic [ARB_IDX_W-1:0] grant_idx,
    output logic                 grant_vld,
    output logic                 preempt,
    output logic                 none_req
);

    arb_state_t           state;
    logic [ARB_IDX_W-1:0] ptr;
    logic [HOLD_W-1:0]    hold_cnt;

    logic [ARB_N-1:0]     pick_oh;
    logic [ARB_IDX_W-1:0] pick_idx;
    logic                 pick_any;

    logic                 rel_hit;
    logic                 req_drop;
    logic                 hold_max;

    rr_pick_8 u_pick (
        .req      (req),
        .ptr      (ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // Exit conditions for the current owner; grant_idx is 0 when idle, and
    // these are only consulted in BUSY.
    always_comb begin
        rel_hit  = rel[grant_idx];
        req_drop = ~req[grant_idx];
        hold_max = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    end

    // FSM, pointer, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= ARB_IDX_W'(ARB_N - 1);
            hold_cnt  <= '0;
            grant_oh  <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            preempt   <= 1'b0;
            none_req  <= 1'b1;
        end else begin
            none_req <= ~|req;
            preempt  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pick_any) begin
                        state     <= BUSY;
                        grant_oh  <= pick_oh;
                        grant_idx <= pick_idx;
                        grant_vld <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (rel_hit || req_drop || hold_max) begin
                        state     <= IDLE;
                        ptr       <= grant_idx;
                        grant_oh  <= '0;
                        grant_idx <= '0;
                        grant_vld <= 1'b0;
                        // Flag only evictions caused purely by the hold limit.
                        preempt   <= hold_max & ~rel_hit & ~req_drop;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : rr_arbiter_8

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: stimulus pushes expected outputs, a monitor pops and compares.
module tb_rr_arbiter_8;

    typedef struct {
        string      name;
        logic [7:0] oh;
        logic [2:0] idx;
        logic       vld;
        logic       pre;
        logic       none;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] rel;
    logic [7:0] grant_oh;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       preempt;
    logic       none_req;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   step_no;

    rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .rel       (rel),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .preempt   (preempt),
        .none_req  (none_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected just after the following rising edge.
    task automatic step(input string name, input logic r, input logic e,
                        input logic [7:0] rq, input logic [7:0] rl,
                        input logic vld, input logic [2:0] idx, input logic pre);
        exp_t x;
        @(negedge clk);
        rst = r;
        en  = e;
        req = rq;
        rel = rl;
        x.name = $sformatf("%s#%0d", name, step_no);
        x.vld  = vld;
        x.idx  = vld ? idx : 3'd0;
        x.oh   = vld ? (8'd1 << idx) : 8'd0;
        x.pre  = pre;
        x.none = r ? 1'b1 : (rq == 8'd0);
        exp_q.push_back(x);
        step_no++;
    endtask

    // Monitor: compare the DUT outputs after each rising edge that has a queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_vec++;
                if (grant_oh !== x.oh || grant_idx !== x.idx || grant_vld !== x.vld ||
                    preempt !== x.pre || none_req !== x.none) begin
                    n_err++;
                    $display("FAIL %s: got oh=%h idx=%0d vld=%b pre=%b none=%b, expected oh=%h idx=%0d vld=%b pre=%b none=%b",
                             x.name, grant_oh, grant_idx, grant_vld, preempt, none_req,
                             x.oh, x.idx, x.vld, x.pre, x.none);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; rel = 8'h00;
        n_vec = 0; n_err = 0; step_no = 0;

        // 1: single requester, release on the third cycle
        step("t1_rst",  1, 0, 8'h00, 8'h00, 0, 0, 0);
        step("t1_g0",   0, 1, 8'h01, 8'h00, 1, 0, 0);
        step("t1_hold", 0, 1, 8'h01, 8'h00, 1, 0, 0);
        step("t1_rel",  0, 1, 8'h01, 8'h01, 0, 0, 0);
        step("t1_idle", 0, 1, 8'h00, 8'h00, 0, 0, 0);

        // 2: all requesting, each owner releases -> 0..7,0 with idle gaps
        step("t2_rst", 1, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int g = 0; g < 9; g++) begin
            step("t2_grant", 0, 1, 8'hFF, 8'h00, 1, 3'(g % 8), 0);
            step("t2_rel",   0, 1, 8'hFF, 8'd1 << (g % 8), 0, 0, 0);
        end
        step("t2_idle", 0, 1, 8'h00, 8'h00, 0, 0, 0);

        // 3: hold limit preemption alternating between 2 and 5
        step("t3_rst", 1, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int k = 0; k < 16; k++) step("t3_g2", 0, 1, 8'h24, 8'h00, 1, 2, 0);
        step("t3_pre2", 0, 1, 8'h24, 8'h00, 0, 0, 1);
        for (int k = 0; k < 16; k++) step("t3_g5", 0, 1, 8'h24, 8'h00, 1, 5, 0);
        step("t3_pre5", 0, 1, 8'h24, 8'h00, 0, 0, 1);
        step("t3_back2", 0, 1, 8'h24, 8'h00, 1, 2, 0);
        step("t3_drop",  0, 1, 8'h00, 8'h00, 0, 0, 0);

        // 4: request drop exit, non-owner rel ignored, pointer moves to 3
        step("t4_rst",   1, 0, 8'h00, 8'h00, 0, 0, 0);
        step("t4_g3",    0, 1, 8'h08, 8'h00, 1, 3, 0);
        step("t4_nrel",  0, 1, 8'h08, 8'hF7, 1, 3, 0);
        step("t4_drop",  0, 1, 8'h00, 8'h00, 0, 0, 0);
        step("t4_g0",    0, 1, 8'h09, 8'h00, 1, 0, 0);
        step("t4_rel0",  0, 1, 8'h09, 8'h01, 0, 0, 0);
        step("t4_g3b",   0, 1, 8'h09, 8'h00, 1, 3, 0);
        step("t4_idle",  0, 1, 8'h00, 8'h00, 0, 0, 0);

        // 5: enable gating
        step("t5_rst",    1, 0, 8'h00, 8'h00, 0, 0, 0);
        step("t5_en0",    0, 0, 8'h10, 8'h10, 0, 0, 0);
        step("t5_en0b",   0, 0, 8'h10, 8'h00, 0, 0, 0);
        step("t5_g4",     0, 1, 8'h10, 8'h00, 1, 4, 0);
        step("t5_hold",   0, 0, 8'h10, 8'h00, 1, 4, 0);
        step("t5_hold2",  0, 0, 8'h10, 8'h00, 1, 4, 0);
        step("t5_rel",    0, 0, 8'h10, 8'h10, 0, 0, 0);
        step("t5_nogr",   0, 0, 8'h10, 8'h00, 0, 0, 0);
        step("t5_idle",   0, 1, 8'h00, 8'h00, 0, 0, 0);

        // 6: reset mid-grant drops it and restores ptr=7
        step("t6_rst",    1, 0, 8'h00, 8'h00, 0, 0, 0);
        step("t6_g6",     0, 1, 8'h40, 8'h00, 1, 6, 0);
        step("t6_hold",   0, 1, 8'h40, 8'h00, 1, 6, 0);
        step("t6_midrst", 1, 1, 8'hC0, 8'h00, 0, 0, 0);
        step("t6_g6b",    0, 1, 8'hC0, 8'h00, 1, 6, 0);
        step("t6_rel6",   0, 1, 8'hC0, 8'h40, 0, 0, 0);
        step("t6_g7",     0, 1, 8'hC0, 8'h00, 1, 7, 0);
        step("t6_end",    0, 1, 8'h00, 8'h00, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_rr_arbiter_8
